// File: rtl/mig_cmd_sched_if.sv
// mig_cmd_sched_if: MIG user (app_*) command, write-data and read-return signals
//   master: scheduler side (drives app_en/cmd/addr and app_wdf_*)
//   slave : MIG side (drives app_rdy, app_wdf_rdy and app_rd_data*)
interface mig_cmd_sched_if #(
    parameter int APP_AW = 28,
    parameter int DW     = 128
);
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [APP_AW-1:0] app_addr;
    logic              app_rdy;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [DW-1:0]     app_wdf_data;
    logic [DW/8-1:0]   app_wdf_mask;
    logic              app_wdf_rdy;
    logic [DW-1:0]     app_rd_data;
    logic              app_rd_data_valid;
    modport master (
        output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
    modport slave (
        input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/mig_cmd_sched.sv
// mig_cmd_sched: pops the request queue and issues read/write commands to the MIG app interface
//   mclk/mrst_n       : clock, async active-low reset
//   request queue     : rqempty, qraddr, rd_bwt in; rnext pop pulse out
//   write-data buffer : wbuf_valid/data/mask in; wbuf_pop pulse out
//   app               : MIG user interface (command, write data, read return)
//   rdata/rdata_valid : read return to requester, one cycle after the MIG
//   busy, rd_err      : activity flag, sticky unexpected-read-data flag
module mig_cmd_sched #(
    parameter int APP_AW = 28,
    parameter int DW     = 128,
    parameter int MAX_RD = 4
) (
    input  logic            mclk,
    input  logic            mrst_n,
    input  logic            init_calib_complete,
    input  logic            rqempty,
    input  logic [31:0]     qraddr,
    input  logic            rd_bwt,
    output logic            rnext,
    input  logic            wbuf_valid,
    input  logic [DW-1:0]   wbuf_data,
    input  logic [DW/8-1:0] wbuf_mask,
    output logic            wbuf_pop,
    mig_cmd_sched_if.master app,
    output logic [DW-1:0]   rdata,
    output logic            rdata_valid,
    output logic            busy,
    output logic            rd_err
);
    typedef enum logic [2:0] {IDLE, WDATA, WCMD, RCMD, POP} state_t;
    localparam logic [2:0] MAX = 3'(MAX_RD);

    state_t            state, state_d;
    logic [2:0]        rd_cnt;
    logic              en_q, en_d, wren_q, wren_d, rnext_d, wpop_d, inc, dec;
    logic [2:0]        cmd_q, cmd_d;
    logic [APP_AW-1:0] addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wmask_q, wmask_d;
    logic              unused_hi;

    assign unused_hi = ^qraddr[31:APP_AW];

    always_comb begin
        state_d = state;
        en_d    = en_q;
        wren_d  = wren_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rnext_d = 1'b0;
        wpop_d  = 1'b0;
        inc     = 1'b0;
        case (state)
            IDLE: if (init_calib_complete && !rqempty) begin
                if (rd_bwt && rd_cnt < MAX) begin
                    state_d = RCMD;
                    en_d    = 1'b1;
                    cmd_d   = 3'b001;
                    addr_d  = qraddr[APP_AW-1:0];
                end else if (!rd_bwt && wbuf_valid) begin
                    // beat is captured here, so wbuf_valid may drop afterwards
                    state_d = WDATA;
                    wren_d  = 1'b1;
                    cmd_d   = 3'b000;
                    addr_d  = qraddr[APP_AW-1:0];
                    wdata_d = wbuf_data;
                    wmask_d = wbuf_mask;
                end
            end
            WDATA: if (app.app_wdf_rdy) begin
                state_d = WCMD;
                wren_d  = 1'b0;
                wpop_d  = 1'b1;
                en_d    = 1'b1;
            end
            WCMD: if (app.app_rdy) begin
                state_d = POP;
                en_d    = 1'b0;
                rnext_d = 1'b1;
            end
            RCMD: if (app.app_rdy) begin
                state_d = POP;
                en_d    = 1'b0;
                rnext_d = 1'b1;
                inc     = 1'b1;
            end
            // dead cycle: lets the queue head settle after the pop
            POP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // read data with nothing outstanding is flagged but never underflows the count
    assign dec = app.app_rd_data_valid && rd_cnt != 3'd0;

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state       <= IDLE;
            rd_cnt      <= 3'd0;
            en_q        <= 1'b0;
            wren_q      <= 1'b0;
            cmd_q       <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rnext       <= 1'b0;
            wbuf_pop    <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rd_err      <= 1'b0;
        end else begin
            state       <= state_d;
            rd_cnt      <= rd_cnt + {2'b0, inc} - {2'b0, dec};
            en_q        <= en_d;
            wren_q      <= wren_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rnext       <= rnext_d;
            wbuf_pop    <= wpop_d;
            rdata       <= app.app_rd_data;
            rdata_valid <= app.app_rd_data_valid;
            rd_err      <= rd_err | (app.app_rd_data_valid && rd_cnt == 3'd0);
        end
    end

    assign app.app_en       = en_q;
    assign app.app_cmd      = cmd_q;
    assign app.app_addr     = addr_q;
    assign app.app_wdf_wren = wren_q;
    assign app.app_wdf_end  = wren_q;
    assign app.app_wdf_data = wdata_q;
    assign app.app_wdf_mask = wmask_q;
    assign busy             = state != IDLE || rd_cnt != 3'd0;
endmodule
